// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, deframes 11-bit frames
// and folds E0/F0 prefixes into a single registered key event per scancode.
module ps2_kbd_rx #(
  parameter int TIMEOUT = 1000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_pressed,
  output logic       key_strobe,
  output logic       frame_err
);

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  logic [1:0]      clk_sync_r;
  logic [1:0]      data_sync_r;
  logic            clk_prev_r;
  state_t          state_r, state_n, cur_s;
  logic [2:0]      cnt_r, cnt_n;
  logic [7:0]      shift_r, shift_n;
  logic            par_ok_r, par_ok_n;
  logic            ext_r, ext_n;
  logic            brk_r, brk_n;
  logic [WD_W-1:0] wd_r, wd_n;
  logic [7:0]      code_n;
  logic            kext_n, kpr_n, strobe_n, err_n;
  logic            fall_s, bit_s, fire_s;

  assign fall_s = clk_prev_r & ~clk_sync_r[1];
  assign bit_s  = data_sync_r[1];
  assign fire_s = (state_r != IDLE) && (wd_r == WD_MAX);

  // Two-flop synchronisers plus the delayed clock used for edge detection.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
      clk_prev_r  <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_kbd_clk};
      data_sync_r <= {data_sync_r[0], ps2_kbd_data};
      clk_prev_r  <= clk_sync_r[1];
    end
  end

  // Frame FSM, prefix tracking, watchdog and next output values.
  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    shift_n  = shift_r;
    par_ok_n = par_ok_r;
    ext_n    = ext_r;
    brk_n    = brk_r;
    code_n   = key_code;
    kext_n   = key_ext;
    kpr_n    = key_pressed;
    strobe_n = 1'b0;
    err_n    = 1'b0;
    wd_n     = wd_r;

    // A watchdog expiry drops to IDLE first, so a coincident edge is handled as an IDLE edge.
    cur_s   = fire_s ? IDLE : state_r;
    state_n = cur_s;

    if (fall_s || (cur_s == IDLE)) begin
      wd_n = '0;
    end else if (wd_r != WD_MAX) begin
      wd_n = wd_r + WD_W'(1);
    end else begin
      wd_n = wd_r;
    end

    if (fall_s) begin
      case (cur_s)
        IDLE: begin
          if (!bit_s) begin
            state_n = DATA;
            cnt_n   = 3'd0;
          end else begin
            err_n = 1'b1;
            ext_n = 1'b0;
            brk_n = 1'b0;
          end
        end
        DATA: begin
          shift_n = {bit_s, shift_r[7:1]};
          cnt_n   = cnt_r + 3'd1;
          if (cnt_r == 3'd7) begin
            state_n = PARITY;
          end else begin
            state_n = DATA;
          end
        end
        PARITY: begin
          par_ok_n = odd_parity_ok(shift_r, bit_s);
          state_n  = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (bit_s && par_ok_r) begin
            if (shift_r == 8'hE0) begin
              ext_n = 1'b1;
            end else if (shift_r == 8'hF0) begin
              brk_n = 1'b1;
            end else begin
              code_n   = shift_r;
              kext_n   = ext_r;
              kpr_n    = ~brk_r;
              strobe_n = 1'b1;
              ext_n    = 1'b0;
              brk_n    = 1'b0;
            end
          end else begin
            err_n = 1'b1;
            ext_n = 1'b0;
            brk_n = 1'b0;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end else begin
      state_n = cur_s;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= 3'd0;
      shift_r     <= 8'h00;
      par_ok_r    <= 1'b0;
      ext_r       <= 1'b0;
      brk_r       <= 1'b0;
      wd_r        <= '0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_pressed <= 1'b0;
      key_strobe  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      shift_r     <= shift_n;
      par_ok_r    <= par_ok_n;
      ext_r       <= ext_n;
      brk_r       <= brk_n;
      wd_r        <= wd_n;
      key_code    <= code_n;
      key_ext     <= kext_n;
      key_pressed <= kpr_n;
      key_strobe  <= strobe_n;
      frame_err   <= err_n;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: directed scenarios then random frames, scored against
// a byte-level model of the scancode/prefix rules.
module tb_ps2_kbd_rx;

  localparam int TIMEOUT = 1000;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_kbd_clk = 1'b1;
  logic       ps2_kbd_data = 1'b1;
  logic [7:0] key_code;
  logic       key_ext, key_pressed, key_strobe, frame_err;

  ps2_kbd_rx #(.TIMEOUT(TIMEOUT)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ps2_kbd_clk (ps2_kbd_clk),
    .ps2_kbd_data(ps2_kbd_data),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_pressed (key_pressed),
    .key_strobe  (key_strobe),
    .frame_err   (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Pulse monitor, sampled on the inactive edge.
  int   strobe_cnt = 0, err_cnt = 0, long_cnt = 0, both_cnt = 0, pulse_cyc = 0;
  logic prev_s = 1'b0, prev_e = 1'b0;
  always @(negedge clk_sys) begin
    if (key_strobe) begin
      strobe_cnt++;
      pulse_cyc = cyc;
      if (prev_s) long_cnt++;
    end
    if (frame_err) begin
      err_cnt++;
      pulse_cyc = cyc;
      if (prev_e) long_cnt++;
    end
    if (key_strobe && frame_err) both_cnt++;
    prev_s = key_strobe;
    prev_e = frame_err;
  end

  int n_vec = 0, n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state: expected pulse totals, visible outputs, prefix flags.
  int         exp_strobe = 0, exp_err = 0, last_fall = 0;
  logic [7:0] m_code = 8'h00;
  logic       m_kext = 1'b0, m_kpr = 1'b0, m_ext = 1'b0, m_brk = 1'b0;

  task automatic model_byte(input logic [7:0] b, input logic good);
    if (!good) begin
      exp_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      exp_strobe++;
      m_code = b;
      m_kext = m_ext;
      m_kpr  = ~m_brk;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    logic par;
    par = 1'b1;
    for (int i = 0; i < 8; i++) par = par ^ b[i];
    return {stop, par ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      ps2_kbd_data = bits[i];
      repeat (half) @(posedge clk_sys);
      #1;
      ps2_kbd_clk = 1'b0;
      last_fall = cyc;
      repeat (half) @(posedge clk_sys);
      #1;
      ps2_kbd_clk = 1'b1;
    end
    ps2_kbd_data = 1'b1;
  endtask

  task automatic check_all(input string tag, input logic pulse);
    check_val($sformatf("%s.strobes", tag), strobe_cnt, exp_strobe);
    check_val($sformatf("%s.errs", tag), err_cnt, exp_err);
    check_val($sformatf("%s.code", tag), {24'd0, key_code}, {24'd0, m_code});
    check_val($sformatf("%s.ext", tag), {31'd0, key_ext}, {31'd0, m_kext});
    check_val($sformatf("%s.pressed", tag), {31'd0, key_pressed}, {31'd0, m_kpr});
    if (pulse) check_val($sformatf("%s.latency", tag), (pulse_cyc - last_fall <= 4) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic frame(input string tag, input logic [7:0] b, input logic bad_par,
                       input logic stop, input int half);
    int s0, e0;
    s0 = exp_strobe;
    e0 = exp_err;
    send_bits(mk_frame(b, bad_par, stop), 11, half);
    model_byte(b, !bad_par && stop);
    repeat (10) @(posedge clk_sys);
    @(negedge clk_sys);
    check_all(tag, (exp_strobe != s0) || (exp_err != e0));
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val($sformatf("%s.code", tag), {24'd0, key_code}, 32'd0);
    check_val($sformatf("%s.ext", tag), {31'd0, key_ext}, 32'd0);
    check_val($sformatf("%s.pressed", tag), {31'd0, key_pressed}, 32'd0);
    check_val($sformatf("%s.strobe", tag), {31'd0, key_strobe}, 32'd0);
    check_val($sformatf("%s.err", tag), {31'd0, frame_err}, 32'd0);
  endtask

  initial begin
    repeat (5) @(posedge clk_sys);
    @(negedge clk_sys);
    check_zero_outputs("por");
    reset_n = 1'b1;
    repeat (5) @(posedge clk_sys);

    frame("make_1c", 8'h1C, 1'b0, 1'b1, 100);
    frame("brk_f0", 8'hF0, 1'b0, 1'b1, 100);
    frame("brk_1c", 8'h1C, 1'b0, 1'b1, 100);
    frame("ext_e0", 8'hE0, 1'b0, 1'b1, 100);
    frame("ext_f0", 8'hF0, 1'b0, 1'b1, 100);
    frame("ext_75", 8'h75, 1'b0, 1'b1, 100);
    frame("plain_75", 8'h75, 1'b0, 1'b1, 100);
    frame("perr_e0", 8'hE0, 1'b0, 1'b1, 100);
    frame("perr_1c", 8'h1C, 1'b1, 1'b1, 100);
    frame("after_perr", 8'h1C, 1'b0, 1'b1, 100);

    // Watchdog: abandoned partial frame, prefix flag survives.
    frame("wd_e0", 8'hE0, 1'b0, 1'b1, 100);
    send_bits(mk_frame(8'h29, 1'b0, 1'b1), 5, 100);
    repeat (TIMEOUT + 10) @(posedge clk_sys);
    @(negedge clk_sys);
    check_val("wd_stall.strobes", strobe_cnt, exp_strobe);
    check_val("wd_stall.errs", err_cnt, exp_err);
    frame("wd_29", 8'h29, 1'b0, 1'b1, 100);

    // Reset in the middle of a frame.
    send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 5, 100);
    @(negedge clk_sys);
    reset_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check_zero_outputs("mid_rst");
    m_code = 8'h00; m_kext = 1'b0; m_kpr = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
    reset_n = 1'b1;
    repeat (5) @(posedge clk_sys);
    frame("post_rst_5a", 8'h5A, 1'b0, 1'b1, 100);

    // Randomised traffic including prefixes, corrupted frames and bad starts.
    for (int it = 0; it < 30; it++) begin
      int kind, half;
      logic [7:0] b;
      kind = $urandom_range(0, 9);
      half = $urandom_range(8, 25);
      b    = 8'($urandom_range(0, 255));
      case (kind)
        0: frame("rnd_perr", b, 1'b1, 1'b1, half);
        1: frame("rnd_stop", b, 1'b0, 1'b0, half);
        2: begin
          send_bits(11'h7FF, 1, half);
          exp_err++;
          m_ext = 1'b0;
          m_brk = 1'b0;
          repeat (10) @(posedge clk_sys);
          @(negedge clk_sys);
          check_all("rnd_start", 1'b1);
        end
        3, 4: frame("rnd_e0", 8'hE0, 1'b0, 1'b1, half);
        5: frame("rnd_f0", 8'hF0, 1'b0, 1'b1, half);
        default: frame("rnd_key", b, 1'b0, 1'b1, half);
      endcase
    end

    check_val("pulse_width", long_cnt, 32'd0);
    check_val("pulse_overlap", both_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1000: clk_sys cycles without a ps2 clock falling edge before a partial frame is abandoned.
REQ-002 SHALL have port clk_sys, input, 1 bit: the single system clock; all logic runs on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port ps2_kbd_clk, input, 1 bit: PS/2 clock from the io block; idles high.
REQ-005 SHALL have port ps2_kbd_data, input, 1 bit: PS/2 data from the io block; idles high.
REQ-006 SHALL have port key_code, output, 8 bits: last decoded scancode, excluding prefixes.
REQ-007 SHALL have port key_ext, output, 1 bit: key_code was preceded by an E0 prefix.
REQ-008 SHALL have port key_pressed, output, 1 bit: 1 for make, 0 for break (F0 prefix seen).
REQ-009 SHALL have port key_strobe, output, 1 bit: one-cycle pulse when key_code, key_ext and key_pressed update.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad start, parity or stop bit.

Function
REQ-011 SHALL pass ps2_kbd_clk and ps2_kbd_data through 2-flop synchronisers (reset value 1) before use.
REQ-012 SHALL detect a ps2 clock falling edge as previous synchronised clock = 1 and current = 0; all bit sampling happens only on such edges, using synchronised data.
REQ-013 SHALL implement a frame FSM with states IDLE, DATA, PARITY and STOP.
REQ-014 IDLE: on an edge with data = 0, go to DATA with bit count 0; on an edge with data = 1, pulse frame_err and stay in IDLE.
REQ-015 DATA: shift the data bit in LSB-first; after the 8th bit, go to PARITY.
REQ-016 PARITY: check odd parity (the 8 data bits plus the parity bit contain an odd number of ones); latch the result; go to STOP.
REQ-017 STOP: if data = 1 and parity is OK, the frame is valid; otherwise pulse frame_err; in both cases return to IDLE.
REQ-018 Valid byte 0xE0 SHALL set the internal ext flag; no strobe.
REQ-019 Valid byte 0xF0 SHALL set the internal brk flag; no strobe.
REQ-020 Any other valid byte SHALL load key_code = byte, key_ext = ext, key_pressed = ~brk, pulse key_strobe, then clear ext and brk.
REQ-021 Prefix order E0 then F0 and repeated prefixes SHALL be accepted; flags are sticky until a non-prefix byte.
REQ-022 frame_err SHALL clear ext and brk; key_code, key_ext and key_pressed hold their values.
REQ-023 key_strobe and frame_err SHALL go high at most 4 clk_sys cycles after the raw stop-bit falling edge, for exactly 1 cycle; they are never high together.
REQ-024 Watchdog: a counter clears on every falling edge and in IDLE; when it reaches TIMEOUT outside IDLE, go to IDLE without any pulse, keeping ext and brk.
REQ-025 The watchdog counter SHALL be wide enough for TIMEOUT and SHALL saturate rather than wrap.
REQ-026 A falling edge in the same cycle the watchdog fires SHALL be treated as the next edge seen in IDLE.
REQ-027 Output registers SHALL change only at a strobe; no combinational path from input to output.

Reset
REQ-028 reset_n low SHALL force asynchronously: FSM = IDLE, bit count 0, ext = brk = 0, watchdog 0, synchronisers = 1, key_code = 0x00, key_ext = 0, key_pressed = 0, key_strobe = 0, frame_err = 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; the first complete frame after release SHALL decode correctly.

Verification
REQ-030 Send frame 0x1C, bit period 200 clk_sys -> one key_strobe, key_code = 0x1C, key_pressed = 1, key_ext = 0.
REQ-031 Send F0, 1C -> single strobe after the second frame, key_code = 0x1C, key_pressed = 0, key_ext = 0.
REQ-032 Send E0, F0, 75 -> single strobe, key_code = 0x75, key_ext = 1, key_pressed = 0; then send 75 -> key_ext = 0, key_pressed = 1.
REQ-033 Send E0, then 0x1C with its parity bit inverted -> frame_err pulse, no strobe; then send 0x1C -> key_ext = 0.
REQ-034 Send 5 bits of a frame, stall the clock high for TIMEOUT + 10 cycles, then send full 0x29 -> no pulse during the stall, then strobe with key_code = 0x29.
REQ-035 Pulse reset_n low after the 4th bit of 0x5A, then send 0x5A -> outputs read 0 during reset, then exactly one strobe with key_code = 0x5A.
